// File: rtl/dii_event_packetizer_if.sv
// rtl/dii_event_packetizer_if.sv - DII flit link between the event packetizer and its ring router
//
// Purpose: groups the valid/ready DII flit signals of one link.
// Signals:
//   out_data   16  flit data
//   out_valid  1   flit valid
//   out_first  1   first flit of a packet
//   out_last   1   last flit of a packet
//   out_ready  1   receiver accepts the flit
// Modports: master drives the flit and samples ready; slave is the router side.
interface dii_event_packetizer_if;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_first;
  logic        out_last;
  logic        out_ready;

  modport master (
    output out_data,
    output out_valid,
    output out_first,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    input  out_first,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/dii_event_packetizer.sv
// rtl/dii_event_packetizer.sv - converts one debug event into a DII packet for the ring router
//
// Purpose: accepts one event (dest + up to MAX_PAYLOAD 16-bit words) while idle, latches it and
//   emits DEST, SRC, FLAGS and the payload words as a first/last framed packet on a registered
//   valid/ready link. One event is in flight at a time.
// Ports:
//   clk              clock
//   rst              synchronous active-high reset
//   id               own ring address, sent as the SRC word (latched at capture)
//   event_dest       destination address, sent as the first flit
//   event_len        payload word count; values above MAX_PAYLOAD are clamped
//   event_payload    payload, word k at [16k+15:16k], word 0 sent first
//   event_available  event request
//   event_consumed   event accepted this cycle (combinational)
//   dii              DII flit link (master side)
module dii_event_packetizer #(
  parameter int          MAX_PAYLOAD = 8,
  parameter logic [1:0]  TYPE        = 2'b10,
  parameter logic [3:0]  TYPE_SUB    = 4'h0,
  localparam int         LEN_W       = $clog2(MAX_PAYLOAD + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [9:0]                 id,
  input  logic [15:0]                event_dest,
  input  logic [LEN_W-1:0]           event_len,
  input  logic [16*MAX_PAYLOAD-1:0]  event_payload,
  input  logic                       event_available,
  output logic                       event_consumed,
  dii_event_packetizer_if.master     dii
);

  localparam int          IDX_W      = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
  localparam logic [15:0] FLAGS_WORD = {TYPE, TYPE_SUB, 10'b0};

  typedef enum logic [2:0] {
    S_IDLE,
    S_DEST,
    S_SRC,
    S_FLAGS,
    S_PAYLOAD
  } state_t;

  state_t           state_q, state_d;
  logic [15:0]      out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             out_first_q, out_first_d;
  logic             out_last_q, out_last_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [9:0]       id_q;
  logic [LEN_W-1:0] len_q;
  logic [15:0]      payload_q [MAX_PAYLOAD];

  logic [LEN_W-1:0] len_clamped;
  logic             xfer;

  assign event_consumed = (state_q == S_IDLE) & event_available & ~rst;
  assign xfer           = out_valid_q & dii.out_ready;
  assign len_clamped    = (event_len > LEN_W'(MAX_PAYLOAD)) ? LEN_W'(MAX_PAYLOAD) : event_len;

  assign dii.out_data  = out_data_q;
  assign dii.out_valid = out_valid_q;
  assign dii.out_first = out_first_q;
  assign dii.out_last  = out_last_q;

  // Every registered output is held unless a flit transfers, so stalls keep the flit stable.
  always_comb begin
    state_d     = state_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_first_d = out_first_q;
    out_last_d  = out_last_q;
    idx_d       = idx_q;

    case (state_q)
      S_IDLE: begin
        if (event_consumed) begin
          state_d     = S_DEST;
          out_valid_d = 1'b1;
          out_first_d = 1'b1;
          out_last_d  = 1'b0;
          out_data_d  = event_dest;
        end
      end
      S_DEST: begin
        if (xfer) begin
          state_d     = S_SRC;
          out_first_d = 1'b0;
          out_data_d  = {6'b0, id_q};
        end
      end
      S_SRC: begin
        if (xfer) begin
          state_d    = S_FLAGS;
          out_data_d = FLAGS_WORD;
          out_last_d = (len_q == '0);
        end
      end
      S_FLAGS, S_PAYLOAD: begin
        if (xfer) begin
          if (out_last_q) begin
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            out_data_d  = '0;
          end else if (state_q == S_FLAGS) begin
            state_d    = S_PAYLOAD;
            idx_d      = '0;
            out_data_d = payload_q[0];
            out_last_d = (len_q == LEN_W'(1));
          end else begin
            idx_d      = idx_q + IDX_W'(1);
            out_data_d = payload_q[idx_d];
            // The word being loaded is index idx_q+1; it is last when idx_q+2 == len.
            out_last_d = ((LEN_W'(idx_q) + LEN_W'(2)) == len_q);
          end
        end
      end
      default: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
        out_first_d = 1'b0;
        out_last_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_first_q <= 1'b0;
      out_last_q  <= 1'b0;
      idx_q       <= '0;
      id_q        <= '0;
      len_q       <= '0;
      for (int k = 0; k < MAX_PAYLOAD; k++) begin
        payload_q[k] <= '0;
      end
    end else begin
      state_q     <= state_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_first_q <= out_first_d;
      out_last_q  <= out_last_d;
      idx_q       <= idx_d;
      // The packet is built only from this latched copy, so event_* may change afterwards.
      if (event_consumed) begin
        id_q  <= id;
        len_q <= len_clamped;
        for (int k = 0; k < MAX_PAYLOAD; k++) begin
          payload_q[k] <= event_payload[16*k +: 16];
        end
      end
    end
  end

endmodule

// File: tb/tb_dii_event_packetizer.sv
// tb/tb_dii_event_packetizer.sv - self-checking bench for dii_event_packetizer
module tb_dii_event_packetizer;
  localparam int          MP        = 8;
  localparam int          LW        = $clog2(MP + 1);
  localparam logic [15:0] FLAGS_EXP = 16'h8000;

  logic             clk = 1'b0;
  logic             rst;
  logic [9:0]       id;
  logic [15:0]      event_dest;
  logic [LW-1:0]    event_len;
  logic [16*MP-1:0] event_payload;
  logic             event_available;
  logic             event_consumed;

  dii_event_packetizer_if dii ();

  dii_event_packetizer #(
    .MAX_PAYLOAD(MP),
    .TYPE(2'b10),
    .TYPE_SUB(4'h0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .id(id),
    .event_dest(event_dest),
    .event_len(event_len),
    .event_payload(event_payload),
    .event_available(event_available),
    .event_consumed(event_consumed),
    .dii(dii)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [15:0] data;
    logic        first;
    logic        last;
  } flit_t;

  flit_t exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [16*MP-1:0] rand_payload();
    logic [16*MP-1:0] p;
    for (int k = 0; k < MP; k++) p[16*k +: 16] = 16'($urandom);
    return p;
  endfunction

  // Reference packet: DEST, SRC, FLAGS, then min(len, MP) payload words.
  task automatic build(input logic [15:0] dest, input logic [9:0] idv, input int len,
                       input logic [16*MP-1:0] pay);
    int n;
    flit_t f;
    n = (len > MP) ? MP : len;
    f.data = dest;          f.first = 1'b1; f.last = 1'b0;     exp_q.push_back(f);
    f.data = {6'b0, idv};   f.first = 1'b0; f.last = 1'b0;     exp_q.push_back(f);
    f.data = FLAGS_EXP;     f.first = 1'b0; f.last = (n == 0); exp_q.push_back(f);
    for (int k = 0; k < n; k++) begin
      f.data = pay[16*k +: 16]; f.first = 1'b0; f.last = (k == n - 1);
      exp_q.push_back(f);
    end
  endtask

  // Offers one event, then follows the packet flit by flit. rst_word >= 0 pulses reset while
  // payload word rst_word is on the link.
  task automatic send(input logic [15:0] dest, input logic [9:0] idv, input int len,
                      input logic [16*MP-1:0] pay, input int ready_pct, input bit hold_avail,
                      input int rst_word);
    int sent;
    int cyc;
    sent = 0;
    cyc  = 0;
    build(dest, idv, len, pay);
    event_dest      = dest;
    id              = idv;
    event_len       = LW'(len);
    event_payload   = pay;
    event_available = 1'b1;
    #1 chk("consumed_pulse", event_consumed, 1);
    @(posedge clk); #1;
    event_dest      = 16'($urandom);
    id              = 10'($urandom);
    event_len       = LW'($urandom);
    event_payload   = rand_payload();
    event_available = hold_avail;
    while (exp_q.size() > 0 && cyc < 400) begin
      dii.out_ready = ($urandom_range(99) < ready_pct);
      #1;
      chk("valid_busy", dii.out_valid, 1);
      chk("data", dii.out_data, exp_q[0].data);
      chk("first", dii.out_first, exp_q[0].first);
      chk("last", dii.out_last, exp_q[0].last);
      chk("consumed_busy", event_consumed, 0);
      if (rst_word >= 0 && sent == 3 + rst_word) begin
        event_available = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("valid_after_rst", dii.out_valid, 0);
        chk("first_after_rst", dii.out_first, 0);
        chk("last_after_rst", dii.out_last, 0);
        exp_q.delete();
      end else begin
        if (dii.out_ready) begin
          void'(exp_q.pop_front());
          sent++;
        end
        @(posedge clk); #1;
      end
      cyc++;
    end
    chk("packet_in_budget", exp_q.size(), 0);
    exp_q.delete();
    #1 chk("idle_gap", dii.out_valid, 0);
    event_available = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst             = 1'b1;
    id              = '0;
    event_dest      = '0;
    event_len       = '0;
    event_payload   = '0;
    event_available = 1'b1;
    dii.out_ready   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_consumed", event_consumed, 0);
    chk("rst_valid", dii.out_valid, 0);
    chk("rst_first", dii.out_first, 0);
    chk("rst_last", dii.out_last, 0);
    chk("rst_data", dii.out_data, 0);
    event_available = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_no_consume", event_consumed, 0);

    // Directed: two payload words, link always ready.
    send(16'h0003, 10'h005, 2, {{(16*(MP-2)){1'b0}}, 16'hBBBB, 16'hAAAA}, 100, 1'b0, -1);
    @(posedge clk); #1;
    // Header-only packet.
    send(16'h0001, 10'h2A5, 0, rand_payload(), 100, 1'b0, -1);
    @(posedge clk); #1;
    // Back-pressure during a three-word packet.
    send(16'h1234, 10'h0F0, 3, rand_payload(), 50, 1'b0, -1);
    @(posedge clk); #1;
    // Continuous requests: each next event must be accepted on the single idle cycle.
    for (int i = 0; i < 4; i++) begin
      send(16'($urandom), 10'($urandom), int'($urandom_range(MP)), rand_payload(), 100, 1'b1, -1);
    end
    // Oversized length is clamped to MP words.
    send(16'hCAFE, 10'h3FF, 15, rand_payload(), 100, 1'b0, -1);
    @(posedge clk); #1;
    // Reset during the second payload word, then a complete packet.
    send(16'h0042, 10'h011, 5, rand_payload(), 100, 1'b0, 1);
    @(posedge clk); #1;
    send(16'h0043, 10'h012, 4, rand_payload(), 100, 1'b0, -1);

    for (int i = 0; i < 25; i++) begin
      repeat ($urandom_range(2)) @(posedge clk);
      #1;
      send(16'($urandom), 10'($urandom), int'($urandom_range(15)), rand_payload(),
           int'($urandom_range(100, 30)), 1'($urandom_range(1)), -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
